vball_gfx_rom_resp: RTL and testbench

VBALL_GFX_ROM_RESP -- requirements
Module: vball_gfx_rom_resp

---
 rtl/vball_gfx_rom_resp.sv | 187 ++++++++++++++++++
 tb/tb_vball_gfx_rom_resp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vball_gfx_rom_resp.sv
// vball_gfx_rom_resp
// Turns a renderer byte request into a ROM/SDRAM word fetch and returns the
// selected byte.
//
// A rising edge on gfx_read starts a fetch. The byte address is latched, and
// its word address is placed on rom_addr. rom_req then stays high until
// rom_ack. The byte chosen by gfx_addr[0] is loaded into gfx_data. A deadline
// counter pulses 'late' once if the ack has not arrived after DEADLINE cycles.
// A rise that arrives while a fetch is in progress is dropped and also pulses
// 'late'.
//
// Optional feature: define VBALL_GFX_CACHE_EN to enable a one-word cache.
// The cache holds the last fetched word and its tag. A request that hits
// the cache finishes without a memory request.
//
// Ports:
//   clk_sys   in   1   system clock, rising edge
//   reset     in   1   asynchronous, active-high reset
//   gfx_addr  in  19   renderer byte address ([18:1] word, [0] byte)
//   gfx_read  in   1   request level; a 0->1 transition starts a fetch
//   gfx_data  out  8   returned byte, held until the next fetch completes
//   rom_addr  out 18   word address to memory
//   rom_req   out  1   memory request, held until acknowledged
//   rom_ack   in   1   memory acknowledge, rom_data valid in the same cycle
//   rom_data  in  16   memory word ([7:0] byte 0, [15:8] byte 1)
//   late      out  1   one-cycle error pulse (deadline miss or dropped request)
module vball_gfx_rom_resp #(
  parameter int DEADLINE = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [18:0] gfx_addr,
  input  logic        gfx_read,
  output logic [7:0]  gfx_data,
  output logic [17:0] rom_addr,
  output logic        rom_req,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  output logic        late
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // dcnt is 4 bits wide and saturates at 15. A deadline above 15 can never
  // be reached, so it maps to a value the counter cannot hold.
  localparam logic [4:0] DEADLINE_CMP = (DEADLINE > 15) ? 5'd31 : 5'(DEADLINE);

  logic [1:0]  state_q, state_d;
  logic        read_q, read_d;
  logic [18:0] addr_q, addr_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  gfx_data_q, gfx_data_d;
  logic [17:0] rom_addr_q, rom_addr_d;
  logic        rom_req_q, rom_req_d;
  logic        late_q, late_d;
  logic        late_seen_q, late_seen_d;
`ifdef VBALL_GFX_CACHE_EN
  logic [17:0] tag_q, tag_d;
  logic        valid_q, valid_d;
`endif

  logic rise;
  logic ack_ok;
  logic hit;

  assign rise   = gfx_read & ~read_q;
  // An ack is accepted only while a request is actually outstanding. An ack
  // that belongs to a request abandoned by reset is therefore ignored.
  assign ack_ok = rom_ack & rom_req_q & (state_q == S_WAIT);

`ifdef VBALL_GFX_CACHE_EN
  assign hit = valid_q & (gfx_addr[18:1] == tag_q);
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    read_d      = gfx_read;
    addr_d      = addr_q;
    dcnt_d      = dcnt_q;
    word_d      = word_q;
    gfx_data_d  = gfx_data_q;
    rom_addr_d  = rom_addr_q;
    rom_req_d   = rom_req_q;
    late_d      = 1'b0;
    late_seen_d = late_seen_q;
`ifdef VBALL_GFX_CACHE_EN
    tag_d       = tag_q;
    valid_d     = valid_q;
`endif

    // The deadline counter runs while a memory fetch is outstanding. The
    // late_seen flag limits each fetch to a single deadline pulse.
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      if (dcnt_q != 4'hF) dcnt_d = dcnt_q + 4'd1;
      if (!ack_ok && !late_seen_q && ({1'b0, dcnt_q} == DEADLINE_CMP)) begin
        late_d      = 1'b1;
        late_seen_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          addr_d      = gfx_addr;
          dcnt_d      = 4'd0;
          late_seen_d = 1'b0;
          if (hit) begin
            gfx_data_d = gfx_addr[0] ? word_q[15:8] : word_q[7:0];
            state_d    = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        rom_addr_d = addr_q[18:1];
        rom_req_d  = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (ack_ok) begin
          rom_req_d  = 1'b0;
          word_d     = rom_data;
          gfx_data_d = addr_q[0] ? rom_data[15:8] : rom_data[7:0];
          state_d    = S_DONE;
`ifdef VBALL_GFX_CACHE_EN
          tag_d      = addr_q[18:1];
          valid_d    = 1'b1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new request is dropped while a fetch is in progress, but it is
    // reported so that the renderer can see the overrun.
    if (rise && state_q != S_IDLE) late_d = 1'b1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      read_q      <= 1'b0;
      addr_q      <= '0;
      dcnt_q      <= '0;
      word_q      <= '0;
      gfx_data_q  <= '0;
      rom_addr_q  <= '0;
      rom_req_q   <= 1'b0;
      late_q      <= 1'b0;
      late_seen_q <= 1'b0;
`ifdef VBALL_GFX_CACHE_EN
      tag_q       <= '0;
      valid_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
      dcnt_q      <= dcnt_d;
      word_q      <= word_d;
      gfx_data_q  <= gfx_data_d;
      rom_addr_q  <= rom_addr_d;
      rom_req_q   <= rom_req_d;
      late_q      <= late_d;
      late_seen_q <= late_seen_d;
`ifdef VBALL_GFX_CACHE_EN
      tag_q       <= tag_d;
      valid_q     <= valid_d;
`endif
    end
  end

  assign gfx_data = gfx_data_q;
  assign rom_addr = rom_addr_q;
  assign rom_req  = rom_req_q;
  assign late     = late_q;

endmodule

// File: tb/tb_vball_gfx_rom_resp.sv
// Directed testbench for vball_gfx_rom_resp with DEADLINE=8.
// It checks behaviour after reset, the normal fetch path, byte selection, the
// deadline pulse, dropped overlapping requests and a reset in the middle of a
// fetch. The expectations for the second read depend on VBALL_GFX_CACHE_EN.
module tb_vball_gfx_rom_resp;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [18:0] gfx_addr;
  logic        gfx_read;
  logic [7:0]  gfx_data;
  logic [17:0] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic        late;

  int errors = 0;
  int checks = 0;
  int late_cnt = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;
  int base_req;
  int base_late;

  vball_gfx_rom_resp #(.DEADLINE(8)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .gfx_addr (gfx_addr),
    .gfx_read (gfx_read),
    .gfx_data (gfx_data),
    .rom_addr (rom_addr),
    .rom_req  (rom_req),
    .rom_ack  (rom_ack),
    .rom_data (rom_data),
    .late     (late)
  );

  always #5 clk_sys = ~clk_sys;

  // Count late pulses and rom_req transactions, sampled away from the
  // active edge.
  always @(negedge clk_sys) begin
    if (late === 1'b1) late_cnt++;
    if (rom_req === 1'b1 && req_prev !== 1'b1) req_rises++;
    req_prev = rom_req;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic [18:0] addr, input logic rd);
    gfx_addr = addr;
    gfx_read = rd;
  endtask

  task automatic applyAck(input logic ack, input logic [15:0] data);
    rom_ack  = ack;
    rom_data = data;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(19'h0, 1'b0);
    applyAck(1'b0, 16'h0);
    tick();
    tick();
    checkOutput("reset_gfx_data", gfx_data, 8'h00);
    checkOutput("reset_rom_addr", rom_addr, 18'h0);
    checkOutput("reset_rom_req", rom_req, 1'b0);
    checkOutput("reset_late", late, 1'b0);
    reset = 1'b0;
    tick();

    // Miss on 0x12345. The ack comes two cycles after rom_req rises.
    base_req  = req_rises;
    base_late = late_cnt;
    applyStimulus(19'h12345, 1'b1);
    tick();
    checkOutput("miss_no_req_yet", rom_req, 1'b0);
    tick();
    checkOutput("miss_rom_req", rom_req, 1'b1);
    checkOutput("miss_rom_addr", rom_addr, 18'h091A2);
    tick();
    tick();
    checkOutput("miss_req_held", rom_req, 1'b1);
    checkOutput("miss_data_before_ack", gfx_data, 8'h00);
    applyAck(1'b1, 16'hBEEF);
    tick();
    checkOutput("miss_gfx_data", gfx_data, 8'hBE);
    checkOutput("miss_req_cleared", rom_req, 1'b0);
    applyAck(1'b0, 16'h0);
    applyStimulus(19'h12345, 1'b0);
    tick();
    checkOutput("miss_one_req", req_rises - base_req, 1);
    checkOutput("miss_no_late", late_cnt - base_late, 0);

    // Second read of the same word, this time the low byte.
    base_req = req_rises;
    applyStimulus(19'h12344, 1'b1);
`ifdef VBALL_GFX_CACHE_EN
    tick();
    checkOutput("hit_gfx_data", gfx_data, 8'hEF);
    checkOutput("hit_no_req", rom_req, 1'b0);
    applyStimulus(19'h12344, 1'b0);
    tick();
    checkOutput("hit_req_count", req_rises - base_req, 0);
`else
    tick();
    checkOutput("byte_data_held", gfx_data, 8'hBE);
    tick();
    checkOutput("byte_rom_req", rom_req, 1'b1);
    checkOutput("byte_rom_addr", rom_addr, 18'h091A2);
    applyAck(1'b1, 16'hBEEF);
    tick();
    checkOutput("byte_gfx_data", gfx_data, 8'hEF);
    checkOutput("byte_req_cleared", rom_req, 1'b0);
    applyAck(1'b0, 16'h0);
    applyStimulus(19'h12344, 1'b0);
    tick();
    checkOutput("byte_req_count", req_rises - base_req, 1);
`endif

    // Deadline case: the ack is held off for 12 cycles after rom_req rises.
    base_late = late_cnt;
    applyStimulus(19'h00010, 1'b1);
    tick();
    tick();
    checkOutput("dl_rom_req", rom_req, 1'b1);
    checkOutput("dl_rom_addr", rom_addr, 18'h00008);
    repeat (8) tick();
    checkOutput("dl_late_pulse", late, 1'b1);
    tick();
    checkOutput("dl_late_single", late, 1'b0);
    repeat (3) tick();
    checkOutput("dl_data_held", gfx_data, 8'hEF);
    checkOutput("dl_req_held", rom_req, 1'b1);
    applyAck(1'b1, 16'h1234);
    tick();
    checkOutput("dl_gfx_data", gfx_data, 8'h34);
    checkOutput("dl_req_cleared", rom_req, 1'b0);
    applyAck(1'b0, 16'h0);
    applyStimulus(19'h00010, 1'b0);
    tick();
    checkOutput("dl_late_count", late_cnt - base_late, 1);

    // Overlap: a second rise during WAIT is dropped and pulses late.
    base_req  = req_rises;
    base_late = late_cnt;
    applyStimulus(19'h00021, 1'b1);
    tick();
    tick();
    checkOutput("ov_rom_req", rom_req, 1'b1);
    applyStimulus(19'h00021, 1'b0);
    tick();
    applyStimulus(19'h00040, 1'b1);
    tick();
    checkOutput("ov_late", late, 1'b1);
    checkOutput("ov_rom_addr_kept", rom_addr, 18'h00010);
    applyAck(1'b1, 16'hA5C3);
    tick();
    checkOutput("ov_gfx_data", gfx_data, 8'hA5);
    checkOutput("ov_late_cleared", late, 1'b0);
    applyAck(1'b0, 16'h0);
    tick();
    applyStimulus(19'h00040, 1'b0);
    tick();
    checkOutput("ov_one_req", req_rises - base_req, 1);
    checkOutput("ov_late_count", late_cnt - base_late, 1);

    // Reset while waiting. The ack that follows must be ignored.
    applyStimulus(19'h00100, 1'b1);
    tick();
    tick();
    checkOutput("rst_req_before", rom_req, 1'b1);
    reset = 1'b1;
    applyStimulus(19'h00100, 1'b0);
    #1;
    checkOutput("rst_req_async", rom_req, 1'b0);
    checkOutput("rst_data_async", gfx_data, 8'h00);
    tick();
    reset = 1'b0;
    applyAck(1'b1, 16'hFFFF);
    tick();
    checkOutput("rst_ack_ignored", gfx_data, 8'h00);
    checkOutput("rst_req_low", rom_req, 1'b0);
    applyAck(1'b0, 16'h0);
    tick();
    checkOutput("rst_data_stays", gfx_data, 8'h00);

    // A fresh fetch must start from IDLE after the reset.
    applyStimulus(19'h00101, 1'b1);
    tick();
    tick();
    checkOutput("post_rst_req", rom_req, 1'b1);
    checkOutput("post_rst_addr", rom_addr, 18'h00080);
    applyAck(1'b1, 16'h7788);
    tick();
    checkOutput("post_rst_data", gfx_data, 8'h77);
    applyAck(1'b0, 16'h0);
    applyStimulus(19'h00101, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
